xnor_match_lock: RTL

- Sequential consumer placed directly downstream of the CMOS XNOR equality gate (its output c).
- Samples the per-bit equality result on each valid cycle and counts consecutive matches.
- Declares lock after a programmable run of matches, and declares loss of lock after a programmable run of consecutive mismatches.
- Provides lock status and one-cycle event pulses to the surrounding frame-sync / comparison logic.

---
 rtl/xnor_match_lock_pkg.sv | 13 +
 rtl/xnor_match_lock_run_counter.sv | 40 ++++
 rtl/xnor_match_lock.sv | 124 ++++++++++++
 3 files changed

// File: rtl/xnor_match_lock_pkg.sv
// Shared definitions for the XNOR match-lock stage and the sync stages downstream of it.
package xnor_match_lock_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int DEF_LOCK_COUNT = 8;
    localparam int DEF_MISS_LIMIT = 3;
    localparam int DEF_CNT_W      = 4;

endpackage

// File: rtl/xnor_match_lock_run_counter.sv
// Clearable, enabled run counter that saturates at LIMIT.
// hit_o flags that the next increment reaches LIMIT.
module xnor_match_lock_run_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         hit_o
);

    localparam logic [W-1:0] LIM_W   = W'(LIMIT);
    localparam logic [W:0]   LIM_W1  = (W+1)'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    assign hit_o = (({1'b0, cnt_q} + 1'b1) == LIM_W1);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xnor_match_lock.sv
// Lock detector behind the XNOR equality gate: declares lock after a run of
// matches and drops it after a run of misses, with one-cycle event pulses.
//
// state  | meaning
// HUNT   | counting consecutive matches toward LOCK_COUNT
// LOCKED | lock held; counting consecutive misses toward MISS_LIMIT
module xnor_match_lock
    import xnor_match_lock_pkg::*;
#(
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int MISS_LIMIT = DEF_MISS_LIMIT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic             eq_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             lock_pulse_o,
    output logic             loss_pulse_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    if (LOCK_COUNT < 1 || LOCK_COUNT > (2**CNT_W) - 1) begin : g_bad_lock_count
        $error("xnor_match_lock: LOCK_COUNT out of range 1..2^CNT_W-1");
    end
    if (MISS_LIMIT < 1 || MISS_LIMIT > (2**CNT_W) - 1) begin : g_bad_miss_limit
        $error("xnor_match_lock: MISS_LIMIT out of range 1..2^CNT_W-1");
    end

    state_e state_q, state_d;
    logic   lock_pulse_q, lock_pulse_d;
    logic   loss_pulse_q, loss_pulse_d;
    logic   match_clr, match_inc, match_hit;
    logic   miss_clr, miss_inc, miss_hit;

    xnor_match_lock_run_counter #(
        .W     (CNT_W),
        .LIMIT (LOCK_COUNT)
    ) u_match_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (match_clr),
        .inc_i   (match_inc),
        .cnt_o   (match_cnt_o),
        .hit_o   (match_hit)
    );

    xnor_match_lock_run_counter #(
        .W     (CNT_W),
        .LIMIT (MISS_LIMIT)
    ) u_miss_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (miss_clr),
        .inc_i   (miss_inc),
        .cnt_o   (miss_cnt_o),
        .hit_o   (miss_hit)
    );

    always_comb begin
        state_d      = state_q;
        lock_pulse_d = 1'b0;
        loss_pulse_d = 1'b0;
        match_clr    = 1'b0;
        match_inc    = 1'b0;
        miss_clr     = 1'b0;
        miss_inc     = 1'b0;

        if (clear_i) begin
            state_d   = HUNT;
            match_clr = 1'b1;
            miss_clr  = 1'b1;
        end else if (in_valid_i) begin
            unique case (state_q)
                HUNT: begin
                    if (eq_i) begin
                        // the counter lands exactly on LOCK_COUNT on the locking sample
                        match_inc = 1'b1;
                        if (match_hit) begin
                            state_d      = LOCKED;
                            lock_pulse_d = 1'b1;
                            miss_clr     = 1'b1;
                        end
                    end else begin
                        match_clr = 1'b1;
                    end
                end
                LOCKED: begin
                    if (eq_i) begin
                        miss_clr = 1'b1;
                    end else if (miss_hit) begin
                        state_d      = HUNT;
                        loss_pulse_d = 1'b1;
                        match_clr    = 1'b1;
                        miss_clr     = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= HUNT;
            lock_pulse_q <= 1'b0;
            loss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_pulse_q <= lock_pulse_d;
            loss_pulse_q <= loss_pulse_d;
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign lock_pulse_o = lock_pulse_q;
    assign loss_pulse_o = loss_pulse_q;

endmodule
